cache_nway_wb: RTL

//  Parametrised N-way set-associative write-back, write-allocate cache with true-LRU replacement.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_nway_wb_if.sv | 42 ++++
 rtl/cache_lru.sv | 50 +++++
 rtl/cache_nway_wb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the N-way write-back cache.
// FSM state encoding plus address/line width functions.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  function automatic int off_w(int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_w(int block_words);
    return $clog2(block_words);
  endfunction

  function automatic int idx_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(int addr_w, int data_w,
                               int block_words, int sets);
    return addr_w - off_w(data_w)
         - word_w(block_words) - idx_w(sets);
  endfunction

  function automatic int line_w(int data_w, int block_words);
    return data_w * block_words;
  endfunction

  // Zero-width fields still need a 1-bit carrier vector.
  function automatic int safe_w(int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/cache_nway_wb_if.sv
// CPU-side and memory-side buses of the cache.
// slave: the cache (answers CPU, issues memory requests); master: CPU + memory.
interface cache_nway_wb_if
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 1
) ();

  localparam int LINE_W = line_w(DATA_W, BLOCK_WORDS);

  logic              cpuReq;
  logic              isRead;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              cpuReady;
  logic              isHit;

  logic              memReq;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [LINE_W-1:0] memWriteData;
  logic [LINE_W-1:0] memReadData;
  logic              memReady;

  modport slave (
    input  cpuReq, isRead, address, writeData,
    output readData, cpuReady, isHit,
    output memReq, memWrite, memAddress, memWriteData,
    input  memReadData, memReady
  );

  modport master (
    output cpuReq, isRead, address, writeData,
    input  readData, cpuReady, isHit,
    input  memReq, memWrite, memAddress, memWriteData,
    output memReadData, memReady
  );

endinterface

// File: rtl/cache_lru.sv
// True-LRU age array: one age counter per way per set, oldest way = victim.
// Ports: clk, reset, set_idx, touch_way, update strobe -> victim way.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int IDX_W = 2,
  parameter int WAY_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             update,
  output logic [WAY_W-1:0] victim
);

  generate
    if (WAYS == 1) begin : g_one
      assign victim = '0;
    end else begin : g_age
      logic [WAY_W-1:0] age [SETS][WAYS];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              age[s][w] <= WAY_W'(w);
        end else if (update) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way)
              age[set_idx][w] <= '0;
            else if (age[set_idx][w] < age[set_idx][touch_way])
              age[set_idx][w] <= age[set_idx][w] + 1'b1;
          end
        end
      end

      // Ages stay a permutation, so exactly one way holds WAYS-1.
      always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++)
          if (age[set_idx][w] == WAY_W'(WAYS - 1))
            victim = WAY_W'(w);
      end
    end
  endgenerate

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back/write-allocate cache, true-LRU.
// Ports: clk, reset, bus (CPU + memory). CACHE_STATS_EN adds hit/miss/wb counters.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAYS        = 2,
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 1
) (
  input  logic            clk,
  input  logic            reset,
  cache_nway_wb_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]     hitCount,
  output logic [31:0]     missCount,
  output logic [31:0]     wbCount
`endif
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int WRD_W  = word_w(BLOCK_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, BLOCK_WORDS, SETS);
  localparam int LINE_W = line_w(DATA_W, BLOCK_WORDS);
  localparam int WRD_S  = safe_w(WRD_W);
  localparam int IDX_S  = safe_w(IDX_W);
  localparam int WAY_S  = safe_w($clog2(WAYS));

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic [DATA_W-1:0] wd_q;
  logic              first_q;
  logic [WAY_S-1:0]  vic_q;

  logic              mreq_q;
  logic              mwr_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [LINE_W-1:0] mwdata_q;

  logic [TAG_W-1:0]  tag_a   [SETS][WAYS];
  logic [LINE_W-1:0] data_a  [SETS][WAYS];
  logic [WAYS-1:0]   valid_a [SETS];
  logic [WAYS-1:0]   dirty_a [SETS];

  logic [WRD_S-1:0]  wsel;
  logic [IDX_S-1:0]  set;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_S-1:0]  hit_way;
  logic [WAY_S-1:0]  vic;
  logic [WAY_S-1:0]  lru_vic;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged;
  logic [DATA_W-1:0] hit_word;
  logic              cpu_done;
  logic              fill;
  logic              wb_done;

  assign wsel = WRD_S'(addr_q >> OFF_W) & WRD_S'(BLOCK_WORDS - 1);
  assign set  = IDX_S'(addr_q >> (OFF_W + WRD_W)) & IDX_S'(SETS - 1);
  assign tag  = TAG_W'(addr_q >> (OFF_W + WRD_W + IDX_W));

  function automatic logic [ADDR_W-1:0] line_addr(
    logic [TAG_W-1:0] t, logic [IDX_S-1:0] s);
    return (ADDR_W'(t) << (OFF_W + WRD_W + IDX_W))
         | (ADDR_W'(s) << (OFF_W + WRD_W));
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_a[set][w] && tag_a[set][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_S'(w);
      end
  end

  // Free ways win over LRU; scan down so the lowest free index sticks.
  always_comb begin
    vic = lru_vic;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_a[set][w])
        vic = WAY_S'(w);
  end

  assign hit_line = data_a[set][hit_way];
  assign hit_word = hit_line[int'(wsel) * DATA_W +: DATA_W];

  always_comb begin
    merged = hit_line;
    merged[int'(wsel) * DATA_W +: DATA_W] = wd_q;
  end

  assign fill    = (state == ALLOCATE) && mreq_q && bus.memReady;
  assign wb_done = (state == WRITEBACK) && mreq_q && bus.memReady;

  always_comb begin
    state_n  = state;
    cpu_done = 1'b0;
    unique case (state)
      IDLE:
        if (bus.cpuReq) state_n = COMPARE;
      COMPARE:
        if (hit) begin
          cpu_done = 1'b1;
          state_n  = IDLE;
        end else if (valid_a[set][vic] && dirty_a[set][vic])
          state_n = WRITEBACK;
        else
          state_n = ALLOCATE;
      WRITEBACK:
        if (wb_done) state_n = ALLOCATE;
      ALLOCATE:
        if (fill) state_n = COMPARE;
      default:
        state_n = IDLE;
    endcase
  end

  assign bus.cpuReady     = cpu_done;
  assign bus.isHit        = cpu_done & first_q;
  assign bus.readData     = cpu_done ? hit_word : '0;
  assign bus.memReq       = mreq_q;
  assign bus.memWrite     = mwr_q;
  assign bus.memAddress   = maddr_q;
  assign bus.memWriteData = mwdata_q;

  // Memory requests are issued from a register, so each transfer
  // leaves a one-cycle memReq gap before the next one starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wd_q     <= '0;
      first_q  <= 1'b0;
      vic_q    <= '0;
      mreq_q   <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE:
          if (bus.cpuReq) begin
            addr_q  <= bus.address;
            rd_q    <= bus.isRead;
            wd_q    <= bus.writeData;
            first_q <= 1'b1;
          end
        COMPARE:
          if (!hit) begin
            first_q <= 1'b0;
            vic_q   <= vic;
          end
        WRITEBACK:
          if (!mreq_q) begin
            mreq_q   <= 1'b1;
            mwr_q    <= 1'b1;
            maddr_q  <= line_addr(tag_a[set][vic_q], set);
            mwdata_q <= data_a[set][vic_q];
          end else if (bus.memReady)
            mreq_q <= 1'b0;
        ALLOCATE:
          if (!mreq_q) begin
            mreq_q   <= 1'b1;
            mwr_q    <= 1'b0;
            maddr_q  <= line_addr(tag, set);
            mwdata_q <= '0;
          end else if (bus.memReady)
            mreq_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_a[s] <= '0;
        dirty_a[s] <= '0;
      end
    end else if (fill) begin
      valid_a[set][vic_q] <= 1'b1;
      dirty_a[set][vic_q] <= 1'b0;
    end else if (cpu_done && !rd_q)
      dirty_a[set][hit_way] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill) begin
        tag_a[set][vic_q]  <= tag;
        data_a[set][vic_q] <= bus.memReadData;
      end else if (cpu_done && !rd_q)
        data_a[set][hit_way] <= merged;
    end
  end

  cache_lru #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_S),
    .WAY_W (WAY_S)
  ) u_lru (
    .clk       (clk),
    .reset     (reset),
    .set_idx   (set),
    .touch_way (hit_way),
    .update    (cpu_done),
    .victim    (lru_vic)
  );

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hitCount  <= '0;
      missCount <= '0;
      wbCount   <= '0;
    end else begin
      if (state == COMPARE && first_q && hit && hitCount != '1)
        hitCount <= hitCount + 32'd1;
      if (state == COMPARE && first_q && !hit && missCount != '1)
        missCount <= missCount + 32'd1;
      if (wb_done && wbCount != '1)
        wbCount <= wbCount + 32'd1;
    end
  end
`endif

endmodule
